// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store execution stage: memory handshake, byte lanes, load extension,
// PC stall and misalignment / timeout reporting.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255  // max REQ cycles without ready; 0 disables
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [1:0]         mem_length,
  input  logic               mem_signed,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  mem_access_unit_if.master  dmem,
  output logic               stall,
  output logic [31:0]        rdata,
  output logic               rdata_valid,
  output logic               misalign,
  output logic               bus_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] LenByte = 2'b01;
  localparam logic [1:0] LenHalf = 2'b10;
  localparam logic [1:0] LenWord = 2'b11;

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      len_q, len_d;
  logic            sign_q, sign_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rdata_valid_q, rdata_valid_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        req_any, req_bad, req_ok;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode, error classification, lane formation for the incoming access.
  always_comb begin
    req_any = (memread | memwrite) && (mem_length != 2'b00);
    req_bad = (memread & memwrite) ||
              ((mem_length == LenHalf) && addr[0]) ||
              ((mem_length == LenWord) && (addr[1:0] != 2'b00));
    req_ok  = req_any && !req_bad;
    be_calc    = 4'b0000;
    wdata_calc = wdata;
    case (mem_length)
      LenByte: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      LenHalf: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      LenWord: be_calc = 4'b1111;
      default: be_calc = 4'b0000;
    endcase
  end

  // Lane select and extension of the returned word, using the captured access shape.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem.dmem_rdata[7:0];
      2'd1:    ld_byte = dmem.dmem_rdata[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata[23:16];
      default: ld_byte = dmem.dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (len_q)
      LenByte: ld_ext = sign_q ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      LenHalf: ld_ext = sign_q ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  // FSM next state and all registered outputs.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    off_d         = off_q;
    len_d         = len_q;
    sign_d        = sign_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    rdata_valid_d = 1'b0;
    misalign_d    = 1'b0;
    bus_err_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_any && req_bad) begin
          misalign_d = 1'b1;
        end else if (req_ok) begin
          state_d = StReq;
          req_d   = 1'b1;
          we_d    = memwrite;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = be_calc;
          wdata_d = wdata_calc;
          off_d   = addr[1:0];
          len_d   = mem_length;
          sign_d  = mem_signed;
          cnt_d   = '0;
        end
      end
      StReq: begin
        // Ready takes priority over a timeout expiring in the same cycle.
        if (dmem.dmem_ready) begin
          req_d   = 1'b0;
          state_d = StDone;
          if (!we_q) begin
            rdata_d       = ld_ext;
            rdata_valid_d = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      off_q         <= '0;
      len_q         <= '0;
      sign_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      off_q         <= off_d;
      len_q         <= len_d;
      sign_q        <= sign_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Stall is gated by reset so it drops as soon as reset asserts.
  always_comb begin
    stall = rst_n && (((state_q == StIdle) && req_ok) || (state_q == StReq));
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign rdata           = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign misalign        = misalign_q;
  assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_access_unit;

  typedef enum int {EvReq, EvStall, EvRdata, EvMis, EvBus} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0, mem_signed = 1'b0;
  logic [1:0]  mem_length = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, rdata_valid, misalign, bus_err;
  logic [31:0] rdata;

  int          n_checks = 0;
  int          n_pass = 0;
  ev_t         exp_q[$];

  int          wait_n = 0;
  int          waited = 0;
  logic [31:0] mem_word = '0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memread     (memread),
    .memwrite    (memwrite),
    .mem_length  (mem_length),
    .mem_signed  (mem_signed),
    .addr        (addr),
    .wdata       (wdata),
    .dmem        (bus.master),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  task automatic expect_event(input ev_kind_e k, output ev_t e, output bit ok);
    logic [31:0] front;
    front = (exp_q.size() > 0) ? 32'(exp_q[0].kind) : 32'hFFFF_FFFF;
    chk("event_kind", 32'(k), front);
    ok = (front == 32'(k));
    if (ok) e = exp_q.pop_front();
  endtask

  // Memory model: ready after wait_n wait cycles of an active request.
  initial begin
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.dmem_req) begin
        bus.dmem_ready = 1'b0;
        waited = 0;
      end else if (waited == wait_n) begin
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = mem_word;
        waited = 0;
      end else begin
        bus.dmem_ready = 1'b0;
        waited++;
      end
    end
  end

  // Monitor: compares every DUT output event against the scoreboard.
  initial begin
    ev_t         e;
    bit          ok;
    logic        prev_req = 1'b0;
    int          stall_cnt = 0;
    logic [31:0] snap_addr = '0, snap_wdata = '0;
    logic [3:0]  snap_be = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        stall_cnt = 0;
      end else begin
        if (bus.dmem_req && !prev_req) begin
          expect_event(EvReq, e, ok);
          if (ok) begin
            chk("req_we", 32'(bus.dmem_we), 32'(e.we));
            chk("req_addr", bus.dmem_addr, e.addr);
            chk("req_be", 32'(bus.dmem_be), 32'(e.be));
            chk("req_wdata", bus.dmem_wdata, e.wdata);
          end
          snap_addr = bus.dmem_addr;
          snap_be = bus.dmem_be;
          snap_wdata = bus.dmem_wdata;
        end else if (bus.dmem_req) begin
          chk("req_hold_addr", bus.dmem_addr, snap_addr);
          chk("req_hold_be_wdata", bus.dmem_wdata ^ 32'(bus.dmem_be),
              snap_wdata ^ 32'(snap_be));
        end
        if (stall) begin
          stall_cnt++;
        end else if (stall_cnt > 0) begin
          expect_event(EvStall, e, ok);
          if (ok) chk("stall_cycles", 32'(stall_cnt), e.val);
          stall_cnt = 0;
        end
        if (rdata_valid) begin
          expect_event(EvRdata, e, ok);
          if (ok) chk("rdata", rdata, e.val);
        end
        if (misalign) expect_event(EvMis, e, ok);
        if (bus_err) expect_event(EvBus, e, ok);
        prev_req = bus.dmem_req;
      end
    end
  end

  task automatic push(input ev_kind_e k, input logic we, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic [31:0] v);
    ev_t e;
    e.kind = k; e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [1:0] len,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
    memread = rd; memwrite = wr; mem_length = len; mem_signed = sg; addr = a; wdata = wd;
  endtask

  // Legal access; called at posedge+1 while IDLE. Returns once back in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [1:0] len,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] mw, input int waits,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input int exp_stall, input bit exp_bus);
    int cyc;
    push(EvReq, wr, {a[31:2], 2'b00}, exp_be, exp_wd, '0);
    push(EvStall, 1'b0, '0, '0, '0, 32'(exp_stall));
    if (exp_bus) push(EvBus, 1'b0, '0, '0, '0, '0);
    else if (rd) push(EvRdata, 1'b0, '0, '0, '0, exp_rd);
    mem_word = mw;
    wait_n = waits;
    set_in(rd, wr, len, sg, a, wd);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (stall && cyc < 50);
    if (cyc >= 50) chk("access_bound", 32'(cyc), 32'd0);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  task automatic bad_access(input logic rd, input logic wr, input logic [1:0] len,
                            input logic [31:0] a);
    push(EvMis, 1'b0, '0, '0, '0, '0);
    set_in(rd, wr, len, 1'b0, a, 32'h1234_5678);
    #1;
    chk("bad_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("bad_req", 32'(bus.dmem_req), 32'd0);
    chk("bad_stall_after", 32'(stall), 32'd0);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    @(posedge clk); #1;
    chk("bad_req_later", 32'(bus.dmem_req), 32'd0);
  endtask

  initial begin
    // Reset values, with a request presented during reset.
    set_in(1'b1, 1'b0, 2'b11, 1'b0, '0, '0);
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_addr_be", bus.dmem_addr | 32'(bus.dmem_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulses", {29'd0, rdata_valid, misalign, bus_err}, 32'd0);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // No-access length: nothing happens.
    set_in(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, '0);
    #1 chk("len0_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("len0_req", 32'(bus.dmem_req), 32'd0);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    @(posedge clk); #1;

    // rd wr len sg addr wdata memword waits be wdata_exp rdata_exp stall bus
    access(1, 0, 2'b01, 1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 4'b1000, 32'h0,
           32'hFFFF_FF80, 2, 0);
    access(1, 0, 2'b10, 0, 32'h2002, 32'h0, 32'h8123_4567, 0, 4'b1100, 32'h0,
           32'h0000_8123, 2, 0);
    access(1, 0, 2'b10, 1, 32'h2000, 32'h0, 32'h0001_8765, 1, 4'b0011, 32'h0,
           32'hFFFF_8765, 3, 0);
    access(1, 0, 2'b01, 0, 32'h2001, 32'h0, 32'h0000_F200, 0, 4'b0010, 32'h0,
           32'h0000_00F2, 2, 0);
    // Ready on the last allowed cycle: completes, no bus error.
    access(0, 1, 2'b01, 0, 32'h3001, 32'h0000_00AB, 32'h0, 3, 4'b0010, 32'hABAB_ABAB,
           32'h0, 5, 0);
    access(0, 1, 2'b10, 0, 32'h6002, 32'h1111_BEEF, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF,
           32'h0, 2, 0);
    chk("rdata_after_store", rdata, 32'h0000_00F2);

    bad_access(1, 0, 2'b11, 32'h4002);
    bad_access(1, 1, 2'b01, 32'h0000_0010);
    bad_access(0, 1, 2'b10, 32'h0000_0021);

    // Timeout: never ready.
    access(1, 0, 2'b11, 0, 32'h7000, 32'h0, 32'hDEAD_BEEF, 1000, 4'b1111, 32'h0,
           32'h0, 5, 1);
    chk("timeout_rdata_hold", rdata, 32'h0000_00F2);

    // Reset in the middle of REQ.
    push(EvReq, 1'b0, 32'h5004, 4'b1111, 32'h0, '0);
    wait_n = 1000;
    set_in(1'b1, 1'b0, 2'b11, 1'b0, 32'h5004, '0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.dmem_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 2'b11, 1, 32'h5000, 32'h0, 32'h89AB_CDEF, 0, 4'b1111, 32'h0,
           32'h89AB_CDEF, 2, 0);

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store execution stage of the single-cycle CPU. Consumes the decoder's memory controls (`memread`, `memwrite`, `mem_length`, `mem_signed`), the ALU result as effective address and the rt operand as store data. Runs a request/ready handshake to the data memory, forms byte enables and store lanes, and sign- or zero-extends load data. Stalls the PC while an access is outstanding and flags misaligned or illegal accesses.

## Interface
- `TIMEOUT`, 255: maximum wait cycles for `dmem_ready`; 0 disables the timeout.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `memread`  in  1  load request from decoder
- `memwrite`  in  1  store request from decoder
- `mem_length`  in  2  00 none, 01 byte, 10 half, 11 word
- `mem_signed`  in  1  sign-extend load result
- `addr`  in  32  effective byte address (ALU result)
- `wdata`  in  32  store operand (rt)
- `dmem_req`  out  1  memory request, registered
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `dmem_be`  out  4  byte enables, bit k = byte lane k
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_ready`  in  1  memory completes the access this cycle
- `dmem_rdata`  in  32  read word, valid with `dmem_ready`
- `stall`  out  1  hold PC/pipeline, combinational
- `rdata`  out  32  extended load result, registered
- `rdata_valid`  out  1  one-cycle pulse when `rdata` is updated
- `misalign`  out  1  one-cycle pulse: misaligned or illegal access
- `bus_err`  out  1  one-cycle pulse: access timed out

## Operation
- FSM states: IDLE, REQ, DONE.
- **Request detection in IDLE.**
  - A request exists when `(memread|memwrite)` and `mem_length!=00`.
  - `mem_length==00` is no access: no stall, no pulse.
- **Error checks.**
  - An access is misaligned when it is half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - `memread&memwrite` together is illegal.
  - In either case, pulse `misalign` on the next cycle, issue no memory access, leave `stall` low and stay in IDLE.
- **Legal access.**
  - IDLE→REQ. On that edge, capture `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, the lane offset, length and sign; set `dmem_req=1`.
  - REQ: hold every `dmem_*` output stable until `dmem_ready`.
  - On `dmem_ready`, drop `dmem_req` and go REQ→DONE. For a load, also register the extracted `rdata` and pulse `rdata_valid`.
- **Timeout.** If `TIMEOUT>0` and REQ has lasted `TIMEOUT` cycles without `dmem_ready`, drop the request, pulse `bus_err`, go to DONE and leave `rdata` unchanged.
- **DONE.** `stall=0` so the instruction retires. No new request is accepted. DONE→IDLE next cycle.
- **Stall equation.** `stall = (IDLE & legal request) | REQ`.
- **Byte enables and lanes** (little-endian, k=`addr[1:0]`).
  - Byte: `be=1<<k`; `wdata` byte replicated to all four lanes.
  - Half: `be=0011` when `addr[1]=0`, else `1100`; halfword replicated to both halves.
  - Word: `be=1111`.
  - Loads drive the same `be`.
- **Load extraction.**
  - Select byte lane k, or half lane `addr[1]`.
  - Extend with bit 7 or bit 15 when `mem_signed=1`; otherwise zero-extend.
  - Word loads pass through unchanged; `mem_signed` is ignored.
- **Reset.** Asserting `rst_n` low at any time, including mid-REQ, returns the FSM to IDLE immediately and clears all outputs. The memory must tolerate `dmem_req` dropping without `ready`.

## Timing
- Reset values: `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_be=0`, `dmem_wdata=0`, `rdata=0`, `rdata_valid=0`, `misalign=0`, `bus_err=0`, state IDLE. `stall` is 0 in reset.
- Minimum access latency with zero-wait memory is 3 cycles: edge 1 enters REQ, edge 2 samples `ready` and enters DONE, edge 3 enters IDLE.
  - `stall` is high for the 2 cycles before DONE.
  - `rdata_valid` is high during the DONE cycle.
- Each additional wait cycle of memory adds one stall cycle.
- `dmem_ready` is ignored outside REQ.
- When `dmem_ready` arrives in the same cycle the timeout count expires, `ready` wins: normal completion, no `bus_err`.
- Inputs from the decoder and ALU must stay stable while `stall=1`. They are sampled only in IDLE.
- Back-to-back memory instructions are separated by at least the DONE cycle.

## Test plan
- **Signed byte load.** Load byte, `addr=0x1003`, `mem_signed=1`, `dmem_rdata=0x80FF_0000`, zero-wait memory.
  - Drive: `dmem_addr=0x1000`, `be=1000`.
  - Result: `rdata=0xFFFF_FF80`, `rdata_valid` pulses in DONE, `stall` high for exactly 2 cycles.
- **Unsigned half load.** Load half, `addr=0x2002`, `mem_signed=0`, `dmem_rdata=0x8123_4567`.
  - Result: `be=1100`, `rdata=0x0000_8123`.
- **Byte store with wait states.** Store byte, `addr=0x3001`, `wdata=0x0000_00AB`, `ready` after 3 wait cycles.
  - Drive: `dmem_we=1`, `be=0010`, `dmem_wdata=0xABAB_ABAB`.
  - Response: request held stable for 4 cycles, `stall` high for 5 cycles, no `rdata_valid`.
- **Misaligned and illegal accesses.**
  - Word load at `addr=0x4002` → `misalign` pulse, `dmem_req` never asserted, `stall=0`.
  - `memread=memwrite=1` → same response.
- **Timeout.** `TIMEOUT=4`, `ready` never asserted.
  - Response: `dmem_req` high for 4 cycles, then a `bus_err` pulse.
  - `rdata` keeps its previous value; the FSM passes through DONE back to IDLE.
- **Reset mid-access.** Pull `rst_n` low in the middle of REQ.
  - Response: `dmem_req` and `stall` drop asynchronously.
  - After release, a new word load at `0x5000` completes normally.
